// File: rtl/filter_readout_sched.sv
// Filter-bank readout scheduler: snapshots all channels on a trigger and streams
// the enabled ones in ascending order over a single valid/ready port.
//
// state | meaning
// IDLE  | waiting for a trigger; no word presented
// SEND  | frame in progress; word at pointer is presented on the output port
module filter_readout_sched #(
    parameter int NUM_CH = 21,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     trigger,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     empty_pulse,
    output logic [DROP_W-1:0]        drop_cnt
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic [DATA_W-1:0] ch_arr [NUM_CH];
    logic [NUM_CH-1:0] mask_q;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  first_idx, next_idx;
    logic [DATA_W-1:0] data_q, data_d;
    logic              has_above;
    logic              xfer;
    logic              load_snap;
    logic              empty_d;
    logic              drop_inc;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
        end
    end

    // Priority encoders: lowest enabled channel at trigger, and lowest mask bit above pointer.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        next_idx  = ptr_q;
        has_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ptr_q))) begin
                next_idx  = IDX_W'(i);
                has_above = 1'b1;
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = (state_q == SEND) && !has_above;
    assign out_ch    = ptr_q;
    assign out_data  = data_q;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        load_snap = 1'b0;
        empty_d   = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    if (|ch_enable) begin
                        load_snap = 1'b1;
                        ptr_d     = first_idx;
                        data_d    = ch_arr[first_idx];
                        state_d   = SEND;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            SEND: begin
                drop_inc = trigger;
                if (xfer) begin
                    if (out_last) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d  = next_idx;
                        data_d = snap_q[next_idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            empty_pulse <= 1'b0;
            drop_cnt    <= '0;
            for (int k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            empty_pulse <= empty_d;
            if (load_snap) begin
                mask_q <= ch_enable;
                for (int k = 0; k < NUM_CH; k++) snap_q[k] <= ch_arr[k];
            end
            if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_filter_readout_sched.sv
// Directed bench for filter_readout_sched: hand-computed expectations checked with
// immediate assertions one cycle step at a time.
module tb_filter_readout_sched;

    localparam int NUM_CH = 21;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;
    localparam int DROP_W = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     trigger;
    logic [DATA_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;
    logic                     empty_pulse;
    logic [DROP_W-1:0]        drop_cnt;

    int checks   = 0;
    int failures = 0;

    filter_readout_sched #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_enable(ch_enable),
        .trigger(trigger), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .empty_pulse(empty_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data_base();
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = DATA_W'(k + 100);
    endtask

    task automatic chk_word(input string tag, input int ch, input int last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(ch + 100));
        chk({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; out_ready = 1'b1; ch_enable = '0;
        set_data_base();
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_empty", 32'(empty_pulse), 32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ch",    32'(out_ch),    32'd0);
        reset = 1'b0;
        tick();

        // Full frame, all channels, ready held high.
        ch_enable = '1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            chk_word("full", k, (k == NUM_CH - 1) ? 1 : 0);
            chk("full_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("full_end_valid", 32'(out_valid), 32'd0);
        chk("full_end_busy",  32'(busy),      32'd0);

        // Sparse mask with stalls; input data changes after snapshot.
        ch_enable = 21'h000005; trigger = 1'b1; out_ready = 1'b1;
        tick();
        trigger = 1'b0;
        ch_data = {NUM_CH{16'hAAAA}};
        ch_enable = '1;
        chk_word("sp_w0", 0, 0);
        tick();
        out_ready = 1'b0;
        chk_word("sp_w1", 2, 1);
        tick();
        chk_word("sp_stall1", 2, 1);
        tick();
        chk_word("sp_stall2", 2, 1);
        out_ready = 1'b1;
        tick();
        chk("sp_end_valid", 32'(out_valid), 32'd0);
        set_data_base();

        // Empty trigger.
        ch_enable = '0; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("empty_pulse_hi", 32'(empty_pulse), 32'd1);
        chk("empty_busy",     32'(busy),        32'd0);
        chk("empty_valid",    32'(out_valid),   32'd0);
        tick();
        chk("empty_pulse_lo", 32'(empty_pulse), 32'd0);
        chk("empty_drop",     32'(drop_cnt),    32'd0);

        // Dropped triggers saturate during a stalled frame.
        ch_enable = 21'h000003; out_ready = 1'b0; trigger = 1'b1;
        tick();
        chk_word("drop_w0", 0, 0);
        for (int n = 0; n < 300; n++) tick();
        trigger = 1'b0;
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk_word("drop_hold", 0, 0);
        out_ready = 1'b1;
        tick();
        chk_word("drop_w1", 1, 1);
        tick();
        chk("drop_end_valid", 32'(out_valid), 32'd0);
        chk("drop_keep", 32'(drop_cnt), 32'd255);

        // Reset mid-frame.
        ch_enable = 21'h00001F; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk_word("rf_w0", 0, 0);
        tick();
        tick();
        chk_word("rf_w2", 2, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rf_valid", 32'(out_valid), 32'd0);
        chk("rf_busy",  32'(busy),      32'd0);
        chk("rf_drop",  32'(drop_cnt),  32'd0);
        ch_enable = 21'h00001C; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk_word("rf_new", 2, 0);
        tick(); tick(); tick();
        chk("rf_end_valid", 32'(out_valid), 32'd0);

        // Single channel; trigger on final transfer drops, next one starts a frame.
        ch_enable = 21'h100000; trigger = 1'b1;
        tick();
        chk_word("one_w", 20, 1);
        tick();
        chk("one_end_valid", 32'(out_valid), 32'd0);
        chk("one_drop",      32'(drop_cnt),  32'd1);
        tick();
        trigger = 1'b0;
        chk_word("one_new", 20, 1);
        chk("one_drop2", 32'(drop_cnt), 32'd1);
        tick();
        chk("one_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_readout_sched.md
Name: filter_readout_sched

Overview:
- Readout scheduler for the filter bank: on a trigger, snapshots every filter channel's output in the same cycle.
- Streams the enabled channels one at a time over a single valid/ready port, in ascending channel order, tagging each word with its channel index.
- Sits between the filter bank's parallel outputs and the downstream readout/serializer, so one narrow link can carry all filter variants.

Parameters:
- NUM_CH, 21, number of filter channels (1..32).
- DATA_W, SIZE_FILTER_DATA, width of one filter output word.
- IDX_W, 5, width of the channel index (must satisfy 2^IDX_W >= NUM_CH).
- DROP_W, 8, width of the dropped-trigger counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_data  in  NUM_CH*DATA_W  flattened filter outputs; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_enable  in  NUM_CH  per-channel readout mask, sampled only at trigger.
- trigger  in  1  single-cycle request to snapshot and read out.
- out_data  out  DATA_W  snapshot word of the current channel.
- out_ch  out  IDX_W  index of the current channel.
- out_valid  out  1  out_data/out_ch/out_last are valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  current word is the last enabled channel of this frame.
- busy  out  1  frame in progress (high while in SEND).
- empty_pulse  out  1  one-cycle pulse when a trigger arrives with ch_enable == 0.
- drop_cnt  out  DROP_W  saturating count of triggers ignored while busy.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - out_valid, out_last, busy, empty_pulse = 0; out_data, out_ch = 0; drop_cnt = 0.
  - Snapshot registers and mask are cleared.
  - Reset asserted mid-frame aborts the frame; no further words are presented.
- FSM states: IDLE, SEND.
- IDLE:
  - Trigger at edge T with ch_enable != 0: latch all ch_data into the snapshot bank and ch_enable into mask.
  - At the same edge, load the pointer with the lowest set mask bit and go to SEND.
  - From T+1: out_valid = 1, busy = 1, out_ch = pointer, out_data = snapshot[pointer].
  - Trigger with ch_enable == 0: stay in IDLE; empty_pulse = 1 for the cycle after T; snapshot unchanged.
- SEND:
  - Handshake: a word transfers on a cycle where out_valid && out_ready.
  - out_data, out_ch and out_last hold stable while out_valid && !out_ready.
  - On transfer with out_last = 0: the pointer moves to the next higher set mask bit; the new word is valid the next cycle. Zero bubbles between words when out_ready is held high.
  - On transfer with out_last = 1: return to IDLE; out_valid and busy go to 0 the next cycle.
  - out_last = 1 iff no mask bit above the pointer is set. It is combinational from registered state, so there is no extra latency.
  - Next-channel search is a priority encoder over mask bits above the pointer, completing in one cycle.
- Trigger while in SEND:
  - Ignored; snapshot and mask are untouched.
  - drop_cnt increments by 1, saturating at 2^DROP_W-1.
  - A trigger in the same cycle as the final transfer also counts as dropped. A new frame requires a trigger in IDLE.
- ch_data and ch_enable changing during SEND have no effect on the current frame.
- Frame latency: first word is valid 1 cycle after the trigger. A full frame of M enabled channels with out_ready held high occupies M cycles of out_valid.
- All outputs are registered except out_last; out_last is derived from registered pointer and mask only.

Test Plan:
- Reset, trigger with ch_enable = all ones, ch_data[k] = k+100, out_ready = 1 -> 21 consecutive words on cycles T+1..T+21: out_ch 0..20, data 100..120; out_last only on ch 20; busy drops at T+22.
- ch_enable = 0x000005, out_ready toggling 1,0,0,1 -> words ch0 then ch2, each held stable through stalls; out_last on ch2 only; ch_data changes during the frame are not reflected.
- Trigger with ch_enable = 0 -> empty_pulse high for exactly one cycle; busy and out_valid stay 0; drop_cnt stays 0.
- Trigger 300 times during a stalled frame (out_ready = 0) -> drop_cnt saturates at 255; frame content unchanged; after release, remaining words drain normally.
- Reset asserted during word 3 of a 5-channel frame -> next cycle out_valid = 0, busy = 0, drop_cnt = 0. A following trigger starts a fresh frame from the lowest enabled channel.
- Single-channel mask 0x100000 -> one word, out_ch = 20 with out_last = 1. A trigger on the transfer cycle is counted as dropped; a trigger on the next cycle starts a new frame.
